eight_bit_sequencer: RTL

EIGHT_BIT_SEQUENCER -- requirements
Module: eight_bit_sequencer

---
 rtl/eight_bit_sequencer_pkg.sv | 59 +++++
 rtl/eight_bit_reg_file.sv | 29 ++
 rtl/eight_bit_sequencer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/eight_bit_sequencer_pkg.sv
// Shared opcodes, instruction field positions and state encoding for the sequencer.
// SEQ_STEP_EN adds the STALL state used by single-step execution.
package eight_bit_sequencer_pkg;

  localparam int OP_MSB = 7;
  localparam int OP_LSB = 4;
  localparam int RD_MSB = 3;
  localparam int RD_LSB = 2;
  localparam int RS_MSB = 1;
  localparam int RS_LSB = 0;

  localparam logic [3:0] OPC_MOV  = 4'b1000;
  localparam logic [3:0] OPC_LDI  = 4'b1001;
  localparam logic [3:0] OPC_OUT  = 4'b1011;
  localparam logic [3:0] OPC_HALT = 4'b1111;

`ifdef SEQ_STEP_EN
  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WAIT_ALU,
    S_FETCH_IMM,
    S_WRITEBACK,
    S_HALT,
    S_STALL
  } state_t;
`else
  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WAIT_ALU,
    S_FETCH_IMM,
    S_WRITEBACK,
    S_HALT
  } state_t;
`endif

  function automatic logic [3:0] opc_f(input logic [7:0] ins);
    return ins[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [1:0] rd_f(input logic [7:0] ins);
    return ins[RD_MSB:RD_LSB];
  endfunction

  function automatic logic [1:0] rs_f(input logic [7:0] ins);
    return ins[RS_MSB:RS_LSB];
  endfunction

  // Opcodes 0000-0111 are all dispatched to the external ALU.
  function automatic logic is_alu(input logic [3:0] op);
    return ~op[3];
  endfunction

endpackage

// File: rtl/eight_bit_reg_file.sv
// 4 x 8 register file: two combinational read ports, one synchronous write port.
// Reads see the pre-write value during a same-cycle write.
module eight_bit_reg_file (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [1:0] waddr,
  input  logic [7:0] wdata,
  input  logic [1:0] raddr_a,
  output logic [7:0] rdata_a,
  input  logic [1:0] raddr_b,
  output logic [7:0] rdata_b
);

  logic [7:0] regs [4];

  // Clear on reset, otherwise write one entry when enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/eight_bit_sequencer.sv
// Fetch/decode/execute sequencer for a 4-register 8-bit core with external ALU.
// Define SEQ_STEP_EN to add the step input and a STALL state after each instruction.
module eight_bit_sequencer
  import eight_bit_sequencer_pkg::*;
#(
  parameter logic [7:0] PC_START    = 8'h00,
  parameter int         ALU_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
`ifdef SEQ_STEP_EN
  input  logic       step,
`endif
  output logic       imem_req,
  output logic [7:0] imem_addr,
  input  logic       imem_valid,
  input  logic [7:0] imem_data,
  output logic [3:0] alu_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_start,
  input  logic       alu_done,
  input  logic [7:0] alu_result,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       busy,
  output logic       halted,
  output logic       error
);

  localparam int TW = $clog2(ALU_TIMEOUT + 1);

  state_t        state;
  state_t        nxt;
  state_t        resume;
  logic [7:0]    pc;
  logic [7:0]    instr;
  logic [7:0]    wb_data;
  logic [TW-1:0] tcnt;
  logic          err_q;

  logic [3:0] op;
  logic [1:0] rd;
  logic [1:0] rs;
  logic [7:0] rdata_a;
  logic [7:0] rdata_b;
  logic       op_alu;
  logic       op_mov;
  logic       op_ldi;
  logic       op_out;
  logic       op_halt;
  logic       op_ill;
  logic       timeout;
  logic       alu_win;

  assign op      = opc_f(instr);
  assign rd      = rd_f(instr);
  assign rs      = rs_f(instr);
  assign op_alu  = is_alu(op);
  assign op_mov  = (op == OPC_MOV);
  assign op_ldi  = (op == OPC_LDI);
  assign op_out  = (op == OPC_OUT);
  assign op_halt = (op == OPC_HALT);
  assign op_ill  = ~(op_alu | op_mov | op_ldi | op_out | op_halt);
  assign timeout = (tcnt == TW'(ALU_TIMEOUT - 1));

`ifdef SEQ_STEP_EN
  assign resume = S_STALL;
`else
  assign resume = S_FETCH;
`endif

  eight_bit_reg_file u_rf (
    .clk     (clk),
    .reset   (reset),
    .we      (state == S_WRITEBACK),
    .waddr   (rd),
    .wdata   (wb_data),
    .raddr_a (rd),
    .rdata_a (rdata_a),
    .raddr_b (rs),
    .rdata_b (rdata_b)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  // Next-state selection.
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:      if (start) nxt = S_FETCH;
      S_FETCH:     if (imem_valid) nxt = S_DECODE;
      S_DECODE:    nxt = S_EXEC;
      S_EXEC: begin
        unique case (1'b1)
          op_alu:  nxt = S_WAIT_ALU;
          op_mov:  nxt = S_WRITEBACK;
          op_ldi:  nxt = S_FETCH_IMM;
          op_out:  nxt = resume;
          default: nxt = S_HALT;
        endcase
      end
      S_WAIT_ALU: begin
        if (alu_done)     nxt = S_WRITEBACK;
        else if (timeout) nxt = S_HALT;
      end
      S_FETCH_IMM: if (imem_valid) nxt = S_WRITEBACK;
      S_WRITEBACK: nxt = resume;
      S_HALT:      if (start) nxt = S_FETCH;
`ifdef SEQ_STEP_EN
      S_STALL:     if (step) nxt = S_FETCH;
`endif
      default:     nxt = S_IDLE;
    endcase
  end

  // PC, instruction, write-back data, ALU wait counter and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= PC_START;
      instr   <= '0;
      wb_data <= '0;
      tcnt    <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) pc <= PC_START;
        end
        S_HALT: begin
          if (start) begin
            pc    <= PC_START;
            err_q <= 1'b0;
          end
        end
        S_FETCH: begin
          if (imem_valid) begin
            instr <= imem_data;
            pc    <= pc + 8'd1;
          end
        end
        S_FETCH_IMM: begin
          if (imem_valid) begin
            wb_data <= imem_data;
            pc      <= pc + 8'd1;
          end
        end
        S_EXEC: begin
          tcnt <= '0;
          if (op_mov) wb_data <= rdata_b;
          if (op_ill) err_q <= 1'b1;
        end
        S_WAIT_ALU: begin
          if (alu_done)     wb_data <= alu_result;
          else if (timeout) err_q   <= 1'b1;
          else              tcnt    <= tcnt + TW'(1);
        end
        default: ;
      endcase
    end
  end

  // ALU operands are presented from launch through the wait.
  assign alu_win   = (state == S_WAIT_ALU) |
                     ((state == S_EXEC) & op_alu);
  assign alu_start = (state == S_EXEC) & op_alu;
  assign alu_op    = alu_win ? op      : 4'h0;
  assign alu_a     = alu_win ? rdata_a : 8'h00;
  assign alu_b     = alu_win ? rdata_b : 8'h00;

  assign imem_req  = (state == S_FETCH) | (state == S_FETCH_IMM);
  assign imem_addr = imem_req ? pc : 8'h00;

  assign out_valid = (state == S_EXEC) & op_out;
  assign out_data  = out_valid ? rdata_a : 8'h00;

  assign busy   = (state != S_IDLE) & (state != S_HALT);
  assign halted = (state == S_HALT);
  assign error  = err_q;

endmodule
